// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply/divide, EX/MEM result register.
// Define MULDIV_SIGNED_EN to make MUL/MULH/DIV/REM two's-complement signed (unsigned otherwise).
module ex_stage_muldiv #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAW       = 5,
    parameter int unsigned MD_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic            in_src2_imm,
    input  logic [RAW-1:0]  in_rs,
    input  logic [RAW-1:0]  in_rt,
    input  logic [RAW-1:0]  in_rd,
    input  logic [XLEN-1:0] in_rs_data,
    input  logic [XLEN-1:0] in_rt_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_regwrite,
    input  logic [RAW-1:0]  exm_rd,
    input  logic [RAW-1:0]  mwb_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic [XLEN-1:0] mwb_data,
    input  logic            exm_regwrite,
    input  logic            mwb_regwrite,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RAW-1:0]  out_rd,
    output logic            out_regwrite,
    output logic [XLEN-1:0] out_store_data,
    output logic            busy
);

    localparam int unsigned STEP = XLEN / MD_CYCLES;
    localparam int unsigned SHW  = $clog2(XLEN);
    localparam int unsigned CNTW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, hi_q, hi_d, lo_q, lo_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic [RAW-1:0]    md_rd_q, md_rd_d;
    logic              md_rw_q, md_rw_d;
    logic [XLEN-1:0]   md_store_q, md_store_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [RAW-1:0]    out_rd_q, out_rd_d;
    logic              out_rw_q, out_rw_d;
    logic [XLEN-1:0]   out_store_q, out_store_d;

    logic [XLEN-1:0]   fwd_a_c, fwd_b_c, op_b_c, alu_c, a_mag_c, b_mag_c, md_result_c;
    logic [XLEN-1:0]   hi_step_c, lo_step_c;
    logic [XLEN:0]     tmp_c, diff_c, sum_c;
    logic [2*XLEN-1:0] prod_c;
    logic              sa_c, sb_c, accept_c, is_md_c, done_load_c;

    // Forwarding: EX/MEM beats MEM/WB, register 0 never forwarded
    assign fwd_a_c = (exm_regwrite && exm_rd == in_rs && in_rs != '0) ? exm_data :
                     (mwb_regwrite && mwb_rd == in_rs && in_rs != '0) ? mwb_data : in_rs_data;
    assign fwd_b_c = (exm_regwrite && exm_rd == in_rt && in_rt != '0) ? exm_data :
                     (mwb_regwrite && mwb_rd == in_rt && in_rt != '0) ? mwb_data : in_rt_data;
    assign op_b_c  = in_src2_imm ? in_imm : fwd_b_c;

    assign in_ready       = !busy_q && (!out_valid_q || out_ready);
    assign accept_c       = in_valid && in_ready;
    assign is_md_c        = (in_op[3:2] == 2'b10);
    assign done_load_c    = (state_q == S_DONE) && (!out_valid_q || out_ready);
    assign busy           = busy_q;
    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_rd         = out_rd_q;
    assign out_regwrite   = out_rw_q;
    assign out_store_data = out_store_q;

`ifdef MULDIV_SIGNED_EN
    assign sa_c = fwd_a_c[XLEN-1];
    assign sb_c = op_b_c[XLEN-1];
`else
    assign sa_c = 1'b0;
    assign sb_c = 1'b0;
`endif
    assign a_mag_c = sa_c ? -fwd_a_c : fwd_a_c;
    assign b_mag_c = sb_c ? -op_b_c : op_b_c;

    always_comb begin
        case (in_op)
            4'd0:    alu_c = fwd_a_c + op_b_c;
            4'd1:    alu_c = fwd_a_c - op_b_c;
            4'd2:    alu_c = fwd_a_c & op_b_c;
            4'd3:    alu_c = fwd_a_c | op_b_c;
            4'd4:    alu_c = fwd_a_c ^ op_b_c;
            4'd5:    alu_c = XLEN'($signed(fwd_a_c) < $signed(op_b_c));
            4'd6:    alu_c = fwd_a_c << op_b_c[SHW-1:0];
            4'd7:    alu_c = fwd_a_c >> op_b_c[SHW-1:0];
            default: alu_c = '0;
        endcase
    end

    // STEP iterations per cycle: shift-add multiply ({hi,lo} = product) or restoring divide (hi = rem, lo = quot)
    always_comb begin
        hi_step_c = hi_q;
        lo_step_c = lo_q;
        tmp_c     = '0;
        diff_c    = '0;
        sum_c     = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (op_q[1]) begin
                tmp_c  = {hi_step_c, lo_step_c[XLEN-1]};
                diff_c = tmp_c - {1'b0, a_q};
                if (!diff_c[XLEN]) begin
                    hi_step_c = diff_c[XLEN-1:0];
                    lo_step_c = {lo_step_c[XLEN-2:0], 1'b1};
                end else begin
                    hi_step_c = tmp_c[XLEN-1:0];
                    lo_step_c = {lo_step_c[XLEN-2:0], 1'b0};
                end
            end else begin
                sum_c = {1'b0, hi_step_c} + (lo_step_c[0] ? {1'b0, a_q} : '0);
                {hi_step_c, lo_step_c} = {sum_c, lo_step_c[XLEN-1:1]};
            end
        end
    end

    // Sign correction and divide-by-zero override applied as the result is loaded
    always_comb begin
        prod_c = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        case (op_q)
            2'd0:    md_result_c = prod_c[XLEN-1:0];
            2'd1:    md_result_c = prod_c[2*XLEN-1:XLEN];
            2'd2:    md_result_c = (a_q == '0) ? '1 : (neg_q ? -lo_q : lo_q);
            default: md_result_c = rneg_q ? -hi_q : hi_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        neg_d        = neg_q;
        rneg_d       = rneg_q;
        md_rd_d      = md_rd_q;
        md_rw_d      = md_rw_q;
        md_store_d   = md_store_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_rw_d     = out_rw_q;
        out_store_d  = out_store_q;
        if (flush) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            out_valid_d = 1'b0;
            out_rw_d    = 1'b0;
        end else begin
            if (out_ready) out_valid_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c && is_md_c) begin
                        state_d    = S_RUN;
                        busy_d     = 1'b1;
                        cnt_d      = '0;
                        op_d       = in_op[1:0];
                        a_d        = in_op[1] ? b_mag_c : a_mag_c;
                        lo_d       = in_op[1] ? a_mag_c : b_mag_c;
                        hi_d       = '0;
                        neg_d      = sa_c ^ sb_c;
                        rneg_d     = sa_c;
                        md_rd_d    = in_rd;
                        md_rw_d    = in_regwrite;
                        md_store_d = fwd_b_c;
                    end else if (accept_c) begin
                        out_valid_d  = 1'b1;
                        out_result_d = alu_c;
                        out_rd_d     = in_rd;
                        out_rw_d     = in_regwrite;
                        out_store_d  = fwd_b_c;
                    end
                end
                S_RUN: begin
                    hi_d  = hi_step_c;
                    lo_d  = lo_step_c;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                end
                S_DONE: begin
                    if (done_load_c) begin
                        state_d      = S_IDLE;
                        busy_d       = 1'b0;
                        out_valid_d  = 1'b1;
                        out_result_d = md_result_c;
                        out_rd_d     = md_rd_q;
                        out_rw_d     = md_rw_q;
                        out_store_d  = md_store_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            neg_q        <= 1'b0;
            rneg_q       <= 1'b0;
            md_rd_q      <= '0;
            md_rw_q      <= 1'b0;
            md_store_q   <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_rw_q     <= 1'b0;
            out_store_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            neg_q        <= neg_d;
            rneg_q       <= rneg_d;
            md_rd_q      <= md_rd_d;
            md_rw_q      <= md_rw_d;
            md_store_q   <= md_store_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_rw_q     <= out_rw_d;
            out_store_q  <= out_store_d;
        end
    end

endmodule
